s_axi_wr_regs: RTL
==================

# s_axi_wr_regs

AXI-Lite slave write endpoint that terminates the write address, write data and write response channels driven by the team's AXI-Lite write master. It captures AW and W independently, commits byte-strobed data into an internal register bank, and returns BRESP. It sits directly downstream of the master on the interconnect-free point-to-point link. It also exposes the bank on a combinational read port and a commit strobe for local logic.

## Interface
- ADDR_W, 32, address width of AWADDR
- NUM_REGS, 16, number of 32-bit registers (power of two, ≥2)
- BASE_ADDR, 32'h0000_0000, byte address of register 0 (4-byte aligned)
- i_clk  in  1  clock
- i_resetn  in  1  reset; synchronous, active-low; clock i_clk
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  ADDR_W  write byte address
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes, bit n enables wdata[8n+7:8n]
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  write response
- i_rd_idx  in  $clog2(NUM_REGS)  register select for local read
- o_rd_data  out  32  regs[i_rd_idx], combinational
- o_wr_pulse  out  1  one-cycle strobe on successful commit
- o_wr_idx  out  $clog2(NUM_REGS)  index committed with o_wr_pulse

## Operation
- States: IDLE, COMMIT, RESP. One outstanding transaction.
- IDLE: s_axi_awready=1 while no address held; s_axi_wready=1 while no data held. AW handshake latches awaddr and sets aw_held. W handshake latches wdata/wstrb and sets w_held. Order free: AW first, W first, or same edge.
- IDLE→COMMIT on the edge where both held flags are (or become) set. Simultaneous AW and W capture on one edge is legal.
- COMMIT, one cycle: offset = awaddr − BASE_ADDR (ADDR_W-bit unsigned); idx = offset[..:2]; offset[1:0] ignored. Hit if awaddr ≥ BASE_ADDR and idx < NUM_REGS.
  - Hit: regs[idx] byte n ← wdata byte n where wstrb[n]=1, else unchanged. bresp ← 2'b00 (OKAY). o_wr_pulse=1, o_wr_idx=idx.
  - Miss: no register change, no pulse, bresp ← 2'b10 (SLVERR).
  - wstrb=4'b0000 on a hit: OKAY, no bytes change, o_wr_pulse still 1.
- COMMIT→RESP unconditionally; s_axi_bvalid=1 in RESP, bresp stable.
- RESP→IDLE on bvalid&&bready; held flags cleared on the same edge.
- bready already high at bvalid assertion: handshake completes in the first RESP cycle.
- awready/wready are 0 in COMMIT and RESP; extra valids are backpressured, never dropped.

## Timing
- All outputs except o_rd_data are registered; no input-to-output combinational path besides i_rd_idx→o_rd_data.
- Reset values: awready=0, wready=0, bvalid=0, bresp=2'b00, o_wr_pulse=0, o_wr_idx=0, all regs=0, state IDLE, held flags 0. awready/wready rise the first cycle after reset release.
- Latency, AW and W handshaked on edge 0: COMMIT in cycle 1, regs visible on o_rd_data from cycle 2, bvalid=1 cycle 2. With bready=1, bvalid low and both readies high in cycle 3.
- A ready drops the cycle after its own handshake; the other channel's ready is unaffected.
- Reset asserted mid-transaction (any state): aborts; no commit if reset is sampled in COMMIT; all state returns to reset values.
- bvalid, once high, stays high with bresp constant until handshake.

## Structure
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, state enum {IDLE, COMMIT, RESP}; the master reuses the response constants.
- Sub-module s_axi_regfile: NUM_REGS×32 storage, byte-strobe merge write port, combinational read port. Top holds the handshake FSM and address decode.

## Test plan
- AW 0x0000_0008 and W 0xDEAD_BEEF/4'hF on the same edge, bready=1 → o_wr_pulse with idx 2; bresp OKAY in cycle 2; regs[2]=0xDEADBEEF.
- W 0x1111_2222/4'b0101 three cycles before AW 0x4; regs[1] preset 0xAABB_CCDD → wready low after W, wait for AW; regs[1]=0xAA11_CC22, OKAY.
- AW 0x0000_0040 (idx 16, NUM_REGS=16) → SLVERR, no pulse, bank unchanged; BASE_ADDR=0x100 with AW 0xFC → SLVERR.
- bready held low 5 cycles after bvalid → bvalid/bresp stable, awready/wready low, second AW stalled until B handshake, then accepted.
- Reset pulsed in COMMIT of a write to idx 3 → regs[3]=0, bvalid never asserts, readies high the cycle after release.
- 32 back-to-back writes, random addr/strb, bready random → scoreboard of bank and bresp matches, no lost or duplicated commits.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI-Lite response codes and write-endpoint FSM states.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, COMMIT, RESP} state_t;
endpackage

// File: rtl/s_axi_regfile.sv
// s_axi_regfile: NUM_REGS x 32 register bank with byte-strobed write and combinational read.
module s_axi_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  logic [31:0]                 wdata,
  input  logic [3:0]                  wstrb,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [31:0]                 rd_data
);
  logic [31:0] regs [NUM_REGS];
  always_ff @(posedge i_clk)
    if (!i_resetn)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) regs[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
  assign rd_data = regs[rd_idx];
endmodule

// File: rtl/s_axi_wr_regs.sv
// s_axi_wr_regs: AXI-Lite write slave terminating AW/W/B into a local register bank.
module s_axi_wr_regs
  import axi_lite_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [ADDR_W-1:0]           s_axi_awaddr,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [31:0]                 s_axi_wdata,
  input  logic [3:0]                  s_axi_wstrb,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [1:0]                  s_axi_bresp,
  input  logic [$clog2(NUM_REGS)-1:0] i_rd_idx,
  output logic [31:0]                 o_rd_data,
  output logic                        o_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] o_wr_idx
);
  localparam int IW = $clog2(NUM_REGS);
  state_t state, state_n;
  logic aw_held, w_held, aw_held_n, w_held_n;
  logic aw_hs, w_hs, hit, pulse_n;
  logic [ADDR_W-1:0] addr_q, word;
  logic [31:0] data_q;
  logic [3:0] strb_q;
  logic [1:0] bresp_n;
  logic [IW-1:0] idx, idx_n;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  // Word offset from the base; the subtraction wraps for addresses below it, hence the explicit >= test.
  assign word = (addr_q - BASE_ADDR) >> 2;
  assign idx = word[IW-1:0];
  assign hit = (addr_q >= BASE_ADDR) && (word < ADDR_W'(NUM_REGS));
  always_comb begin
    state_n = state;
    aw_held_n = aw_held;
    w_held_n = w_held;
    bresp_n = s_axi_bresp;
    pulse_n = 1'b0;
    idx_n = o_wr_idx;
    unique case (state)
      IDLE: begin
        aw_held_n = aw_held || aw_hs;
        w_held_n = w_held || w_hs;
        state_n = (aw_held_n && w_held_n) ? COMMIT : IDLE;
      end
      COMMIT: begin
        state_n = RESP;
        bresp_n = hit ? RESP_OKAY : RESP_SLVERR;
        pulse_n = hit;
        idx_n = hit ? idx : o_wr_idx;
      end
      RESP: begin
        state_n = s_axi_bready ? IDLE : RESP;
        aw_held_n = s_axi_bready ? 1'b0 : aw_held;
        w_held_n = s_axi_bready ? 1'b0 : w_held;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (!i_resetn) begin
      state <= IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      o_wr_pulse <= 1'b0;
      o_wr_idx <= '0;
    end else begin
      state <= state_n;
      aw_held <= aw_held_n;
      w_held <= w_held_n;
      s_axi_awready <= (state_n == IDLE) && !aw_held_n;
      s_axi_wready <= (state_n == IDLE) && !w_held_n;
      s_axi_bvalid <= state_n == RESP;
      s_axi_bresp <= bresp_n;
      o_wr_pulse <= pulse_n;
      o_wr_idx <= idx_n;
    end
  always_ff @(posedge i_clk) begin
    if (aw_hs) addr_q <= s_axi_awaddr;
    if (w_hs) begin
      data_q <= s_axi_wdata;
      strb_q <= s_axi_wstrb;
    end
  end
  // Gating with i_resetn drops a commit whose COMMIT cycle coincides with reset.
  s_axi_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .we      ((state == COMMIT) && hit && i_resetn),
    .wr_idx  (idx),
    .wdata   (data_q),
    .wstrb   (strb_q),
    .rd_idx  (i_rd_idx),
    .rd_data (o_rd_data)
  );
endmodule
